// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter merging NUM_REQ producer write requests into one FIFO write port.
// Latency : req sampled in IDLE -> fifo_wr_en next cycle -> gnt 3 cycles after the sample; 4 cycles per access.
// Backpressure: fifo_full holds the FSM in IDLE; a missing fifo_wr_ack retries the same winner.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   arb_en             : allow new arbitrations (an in-flight access always completes)
//   req / req_data     : per-producer request and data (producer i at [i*FIFO_WIDTH +: FIFO_WIDTH])
//   gnt                : one-cycle pulse, word from producer i accepted by the FIFO
//   fifo_wr_en/_data_in: registered FIFO write strobe and data
//   fifo_full          : FIFO full flag
//   fifo_wr_ack        : write acknowledge, one cycle after fifo_wr_en
//   fifo_overflow      : overflow flag, one cycle after fifo_wr_en
//   busy               : FSM not in IDLE
//   overflow_err       : sticky, set by any fifo_overflow seen on a failed attempt
//   retry_cnt          : saturating count of failed write attempts
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic                          overflow_err,
    output logic [7:0]                    retry_cnt
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDXW = IW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [IW-1:0]         winner;
    logic [IW-1:0]         rr_ptr;
    logic                  pending;

    logic [IW-1:0]         arb_idx;
    logic                  arb_found;
    logic [IDXW-1:0]       cand;
    logic [IW-1:0]         sel_idx;
    logic [FIFO_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    winner_dec;
    logic [IW-1:0]         nxt_ptr;
    logic                  start;

    // Rotating priority search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + IDXW'(k);
            if (cand >= IDXW'(NUM_REQ)) begin
                cand = cand - IDXW'(NUM_REQ);
            end
            if (!arb_found && req[cand[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IW-1:0];
            end
        end
    end

    // A retry keeps its winner; only a fresh access re-arbitrates.
    assign sel_idx = pending ? winner : arb_idx;

    always_comb begin
        sel_data   = '0;
        winner_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel_idx) begin
                sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
            if (IW'(i) == winner) begin
                winner_dec[i] = 1'b1;
            end
        end
    end

    assign nxt_ptr = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign start   = (state == S_IDLE) && arb_en && !fifo_full && (pending || (req != '0));
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            winner       <= '0;
            rr_ptr       <= '0;
            pending      <= 1'b0;
            gnt          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            overflow_err <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    gnt <= '0;
                    if (start) begin
                        state        <= S_ISSUE;
                        winner       <= sel_idx;
                        fifo_wr_en   <= 1'b1;
                        fifo_data_in <= sel_data;
                    end
                end
                S_ISSUE: begin
                    // Single-cycle write strobe per attempt.
                    fifo_wr_en <= 1'b0;
                    state      <= S_CHECK;
                end
                S_CHECK: begin
                    if (fifo_wr_ack) begin
                        gnt     <= winner_dec;
                        rr_ptr  <= nxt_ptr;
                        pending <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        pending      <= 1'b1;
                        retry_cnt    <= (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
                        overflow_err <= overflow_err | fifo_overflow;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    // DONE: gives the granted producer one cycle to drop req
                    // before the next arbitration can see it.
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : self-checking bench for fifo_wr_arbiter (vector table + scoreboard + corner sequences).
// Latency : n/a (simulation only).
// Backpressure: bench FIFO model acks every write unless fail_mode is set; fifo_full driven directly.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arb_en = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_ack = 1'b0;
    logic           fifo_overflow = 1'b0;
    logic           busy;
    logic           overflow_err;
    logic [7:0]     retry_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arb_en        (arb_en),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .busy          (busy),
        .overflow_err  (overflow_err),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered ack/overflow one cycle after the write strobe.
    bit fail_mode = 1'b0;
    bit ovf_mode  = 1'b0;
    always @(posedge clk) begin
        fifo_wr_ack   <= fifo_wr_en && !fail_mode;
        fifo_overflow <= fifo_wr_en && ovf_mode;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected {port, data} pushed when a request is driven.
    typedef struct {
        int           port;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] last_wr = '0;

    always @(negedge clk) begin
        if (rst_n && fifo_wr_en) last_wr = fifo_data_in;
        if (rst_n && gnt != '0) begin
            chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("gnt_port", 32'(gnt), 32'd1 << mon_e.port);
                chk("gnt_data", 32'(last_wr), 32'(mon_e.data));
            end
        end
    end

    task automatic set_data(input int p, input logic [W-1:0] d);
        req_data[p*W +: W] = d;
    endtask

    task automatic wait_gnt(input int port, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt[port]) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) chk("gnt_timeout", 32'(port), 32'hFFFF_FFFF);
    endtask

    function automatic logic [W-1:0] vdata(input int a, input int p);
        return W'(32'hC000 + a * 16 + p);
    endfunction

    typedef struct {
        logic [N-1:0] req;
        int           port;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int tg;
        int cnt;
        int gcyc[5];

        // Expected grant for each vector follows the round-robin pointer left by the previous one.
        tbl[0] = '{4'b1001, 3};   // rr=3 after the A5A5 access
        tbl[1] = '{4'b0110, 1};   // rr=0
        tbl[2] = '{4'b0011, 0};   // rr=2 -> wraps to 0
        tbl[3] = '{4'b1000, 3};   // rr=1
        tbl[4] = '{4'b1110, 1};   // rr=0
        tbl[5] = '{4'b0101, 2};   // rr=2
        tbl[6] = '{4'b0001, 0};   // rr=3 -> wraps to 0

        repeat (3) @(negedge clk);
        chk("rst_gnt",       32'(gnt),          32'd0);
        chk("rst_wr_en",     32'(fifo_wr_en),   32'd0);
        chk("rst_data",      32'(fifo_data_in), 32'd0);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_ovf_err",   32'(overflow_err), 32'd0);
        chk("rst_retry_cnt", 32'(retry_cnt),    32'd0);

        rst_n  = 1'b1;
        arb_en = 1'b1;
        @(negedge clk);

        // Single request on port 2: latency and data path.
        set_data(2, 16'hA5A5);
        req = 4'b0100;
        sb.push_back('{2, 16'hA5A5});
        @(negedge clk);
        chk("a5_wr_en",   32'(fifo_wr_en),   32'd1);
        chk("a5_data",    32'(fifo_data_in), 32'hA5A5);
        chk("a5_busy",    32'(busy),         32'd1);
        @(negedge clk);
        chk("a5_wr_pulse", 32'(fifo_wr_en),  32'd0);
        chk("a5_gnt_early", 32'(gnt),        32'd0);
        @(negedge clk);
        chk("a5_gnt",     32'(gnt),          32'b0100);
        req = '0;
        @(negedge clk);
        chk("a5_gnt_drop", 32'(gnt),         32'd0);
        chk("a5_idle",    32'(busy),         32'd0);

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            for (int p = 0; p < N; p++) set_data(p, vdata(i, p));
            req = tbl[i].req;
            sb.push_back('{tbl[i].port, vdata(i, tbl[i].port)});
            wait_gnt(tbl[i].port, 20, tg);
            req = '0;
            @(negedge clk);
        end

        // FIFO full holds the request in IDLE.
        fifo_full = 1'b1;
        set_data(0, 16'h0BAD);
        req = 4'b0001;
        sb.push_back('{0, 16'h0BAD});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("full_busy",  32'(busy),       32'd0);
            chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("full_gnt",   32'(gnt),        32'd0);
        end
        fifo_full = 1'b0;
        wait_gnt(0, 10, tg);
        req = '0;
        @(negedge clk);

        // Failed attempt with overflow; port 1 (which would win from rr=1) is ignored.
        set_data(2, 16'h2222);
        set_data(1, 16'h1111);
        req       = 4'b0100;
        fail_mode = 1'b1;
        ovf_mode  = 1'b1;
        sb.push_back('{2, 16'h2222});
        @(negedge clk);
        chk("fail_issue", 32'(fifo_wr_en), 32'd1);
        @(negedge clk);
        fail_mode = 1'b0;
        ovf_mode  = 1'b0;
        req       = 4'b0110;
        @(negedge clk);
        chk("fail_retry_cnt", 32'(retry_cnt),    32'd1);
        chk("fail_ovf_err",   32'(overflow_err), 32'd1);
        chk("fail_idle",      32'(busy),         32'd0);
        @(negedge clk);
        chk("reissue_wr_en",  32'(fifo_wr_en),   32'd1);
        chk("reissue_data",   32'(fifo_data_in), 32'h2222);
        wait_gnt(2, 10, tg);
        req = 4'b0010;
        sb.push_back('{1, 16'h1111});
        wait_gnt(1, 10, tg);
        req = '0;
        @(negedge clk);

        // 300 more failures: retry_cnt saturates.
        set_data(0, 16'h5A5A);
        req       = 4'b0001;
        fail_mode = 1'b1;
        sb.push_back('{0, 16'h5A5A});
        cnt = 0;
        for (int k = 0; k < 2000 && cnt < 300; k++) begin
            @(negedge clk);
            if (fifo_wr_en) cnt++;
        end
        chk("fail_attempts", 32'(cnt), 32'd300);
        @(negedge clk);
        fail_mode = 1'b0;
        wait_gnt(0, 20, tg);
        chk("sat_retry_cnt", 32'(retry_cnt),    32'd255);
        chk("sticky_ovf",    32'(overflow_err), 32'd1);
        req = '0;
        @(negedge clk);

        // Reset during ISSUE abandons the access.
        set_data(1, 16'h7777);
        req = 4'b0010;
        sb.push_back('{1, 16'h7777});
        @(negedge clk);
        chk("mid_issue", 32'(fifo_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(gnt),          32'd0);
        chk("mid_rst_wr_en", 32'(fifo_wr_en),   32'd0);
        chk("mid_rst_data",  32'(fifo_data_in), 32'd0);
        chk("mid_rst_busy",  32'(busy),         32'd0);
        chk("mid_rst_ovf",   32'(overflow_err), 32'd0);
        chk("mid_rst_retry", 32'(retry_cnt),    32'd0);
        sb.delete();
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_gnt", 32'(gnt), 32'd0);
        end

        // All four requesting: order 0,1,2,3,0 from a fresh pointer, one grant every 4 cycles.
        for (int p = 0; p < N; p++) begin
            set_data(p, W'(32'h3000 + p));
            sb.push_back('{p, W'(32'h3000 + p)});
        end
        sb.push_back('{0, 16'h3100});
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_gnt(j % N, 20, gcyc[j]);
            set_data(j % N, W'(32'h3100 + (j % N)));
            if (j == 4) req = '0;
        end
        for (int j = 1; j < 5; j++) begin
            chk("rr_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'd4);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producer ports; the arbiter SHALL support NUM_REQ from 2 to 8.
REQ-002 Parameter FIFO_WIDTH, default 16: width of the data word on every producer port and on the FIFO port.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port arb_en, input, 1: when 0, the arbiter SHALL start no new arbitration; an access already in flight SHALL complete.
REQ-006 Port req, input, NUM_REQ: per-producer write request, held high until that producer's gnt pulse.
REQ-007 Port req_data, input, NUM_REQ*FIFO_WIDTH: producer i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH], held stable while req[i]=1.
REQ-008 Port gnt, output, NUM_REQ: one-cycle registered pulse meaning the word from producer i was accepted by the FIFO.
REQ-009 Port fifo_wr_en, output, 1: registered write enable to the FIFO.
REQ-010 Port fifo_data_in, output, FIFO_WIDTH: registered write data to the FIFO.
REQ-011 Port fifo_full, input, 1: FIFO full flag.
REQ-012 Port fifo_wr_ack, input, 1: FIFO write acknowledge, registered one cycle after fifo_wr_en.
REQ-013 Port fifo_overflow, input, 1: FIFO overflow flag, registered one cycle after fifo_wr_en.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port overflow_err, output, 1: sticky flag, set on any observed fifo_overflow.
REQ-016 Port retry_cnt, output, 8: saturating count of failed write attempts.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CHECK and DONE; the state register SHALL be the only control state besides winner, pending, rr_ptr and the status registers.
REQ-018 IDLE -> ISSUE when arb_en=1, fifo_full=0, and either pending=1 or req!=0; on that edge fifo_wr_en<=1 and fifo_data_in<=req_data[winner].
REQ-019 With pending=0, winner SHALL be the first i with req[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ; with pending=1, winner SHALL be retained and no arbitration SHALL occur.
REQ-020 ISSUE -> CHECK unconditionally; fifo_wr_en<=0 on that edge, so fifo_wr_en is high for exactly one cycle per attempt.
REQ-021 In CHECK with fifo_wr_ack=1: gnt[winner]<=1, rr_ptr<=(winner+1) mod NUM_REQ, pending<=0, and next state DONE.
REQ-022 In CHECK with fifo_wr_ack=0: pending<=1, retry_cnt<=min(retry_cnt+1,255), overflow_err<=overflow_err|fifo_overflow, and next state IDLE.
REQ-023 DONE -> IDLE unconditionally, with gnt<=0; no arbitration SHALL occur in DONE, so a producer has one cycle to drop req.
REQ-024 Latency from a req sampled in IDLE to gnt high SHALL be 3 cycles, and one access SHALL take 4 cycles, IDLE through DONE.
REQ-025 gnt SHALL be one-hot or zero at all times.
REQ-026 Deasserting req[winner] before gnt is a protocol violation; the arbiter SHALL still complete the access using the registered data.
REQ-027 fifo_full=1 in IDLE SHALL hold the FSM in IDLE with winner and pending unchanged.
REQ-028 A req on any port other than winner SHALL not affect an in-flight access.

Reset
REQ-029 While rst_n=0: state=IDLE, rr_ptr=0, winner=0, pending=0, gnt=0, fifo_wr_en=0, fifo_data_in=0, busy=0, overflow_err=0, retry_cnt=0.
REQ-030 Reset asserted mid-access SHALL abandon the access immediately with no gnt pulse.
REQ-031 overflow_err and retry_cnt SHALL clear only on reset.

Verification
REQ-032 Stimulus: req=4'b0100, data2=16'hA5A5, FIFO empty. Required: fifo_wr_en=1 with fifo_data_in=16'hA5A5 one cycle later, gnt=4'b0100 three cycles after the req sample, rr_ptr=3.
REQ-033 Stimulus: req=4'b1111 held with fresh data after each gnt. Required: grant order 0,1,2,3,0 and one gnt every 4 cycles.
REQ-034 Stimulus: FIFO with count=32 (full), req=4'b0001. Required: FSM stays IDLE, fifo_wr_en=0, no gnt; after a FIFO read clears fifo_full, the write issues and gnt[0] pulses.
REQ-035 Stimulus: fifo_wr_ack=0 and fifo_overflow=1 forced in CHECK. Required: retry_cnt=1, overflow_err=1, the same winner is reissued and req from other ports is ignored.
REQ-036 Stimulus: 300 forced failures. Required: retry_cnt saturates at 255.
REQ-037 Stimulus: rst_n driven low during ISSUE with arb_en=1. Required: all outputs at reset values and no gnt pulse; after release, arbitration restarts from port 0.
